// File: rtl/gmac_tx_framer.sv
// Target-report framer: buffers range/energy records and streams them
// as raw Ethernet frames into the GMAC transmit AXI-stream port.
module gmac_tx_framer #(
  parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC  = 48'h000A_3500_0001,
  parameter logic [15:0] ETH_TYPE = 16'h88B5,
  parameter int          MAX_TGT  = 16,
  parameter int          FIFO_AW  = 5
) (
  input  logic        I_tx_mac_aclk,
  input  logic        I_tx_reset,
  input  logic        I_target_ena,
  input  logic [15:0] I_target_range,
  input  logic [31:0] I_target_energy,
  input  logic        I_target_end,
  output logic [7:0]  O_tx_axis_mac_tdata,
  output logic        O_tx_axis_mac_tvalid,
  output logic        O_tx_axis_mac_tlast,
  input  logic        I_tx_axis_mac_tready,
  output logic        O_fifo_overflow,
  output logic [15:0] O_frame_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] MAX_C = (FIFO_AW + 1)'(MAX_TGT);
  localparam logic [FIFO_AW:0] FULL_C = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, HDR, REC, PAD} state_t;

  logic [47:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   fifo_cnt;
  logic               full, wr_en, pop;
  logic [47:0]        head;

  state_t      state, state_n;
  logic [10:0] idx, idx_n, nidx;
  logic [10:0] total, total_n, rec_end;
  logic [2:0]  roff, roff_n;
  logic [7:0]  n_lat, n_n, n_sel;
  logic [47:0] rec_q, rec_n;
  logic [7:0]  tdata_q, tdata_n;
  logic        tvalid_q, tvalid_n;
  logic        tlast_q, tlast_n;
  logic [15:0] seq, frame_cnt;
  logic        flush_req, clr_flush, done, start, ovf;

  function automatic logic [10:0] frame_len(input logic [7:0] n);
    logic [10:0] l;
    l = 11'd18 + 11'(n) * 11'd6;
    return (l < 11'd60) ? 11'd60 : l;
  endfunction

  function automatic logic [7:0] hdr_byte(
    input logic [4:0]  i,
    input logic [15:0] s,
    input logic [7:0]  n
  );
    logic [143:0] h;
    h = {DST_MAC, SRC_MAC, ETH_TYPE, s, n, 8'h00};
    return h[143 - 8 * int'(i) -: 8];
  endfunction

  function automatic logic [7:0] rec_byte(
    input logic [47:0] r,
    input logic [2:0]  o
  );
    case (o)
      3'd1:    return r[39:32];
      3'd2:    return r[31:24];
      3'd3:    return r[23:16];
      3'd4:    return r[15:8];
      3'd5:    return r[7:0];
      default: return r[47:40];
    endcase
  endfunction

  assign full    = fifo_cnt == FULL_C;
  assign wr_en   = I_target_ena && !full;
  assign head    = mem[rd_ptr];
  assign start   = (fifo_cnt >= MAX_C) || flush_req;
  assign n_sel   = (fifo_cnt >= MAX_C) ? 8'(MAX_TGT) : 8'(fifo_cnt);
  assign nidx    = idx + 11'd1;
  assign rec_end = 11'd18 + 11'(n_lat) * 11'd6;

  always_ff @(posedge I_tx_mac_aclk) begin
    if (wr_en) mem[wr_ptr] <= {I_target_range, I_target_energy};
  end

  // Full means full even if a pop happens this cycle: the write drops.
  always_ff @(posedge I_tx_mac_aclk or posedge I_tx_reset) begin
    if (I_tx_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      ovf       <= 1'b0;
      flush_req <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (FIFO_AW + 1)'(wr_en)
                           - (FIFO_AW + 1)'(pop);
      if (I_target_ena && full) ovf <= 1'b1;
      if (I_target_end)   flush_req <= 1'b1;
      else if (clr_flush) flush_req <= 1'b0;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    roff_n    = roff;
    n_n       = n_lat;
    total_n   = total;
    rec_n     = rec_q;
    tdata_n   = tdata_q;
    tvalid_n  = tvalid_q;
    tlast_n   = tlast_q;
    pop       = 1'b0;
    clr_flush = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        tvalid_n = 1'b0;
        tlast_n  = 1'b0;
        if (start) begin
          state_n   = HDR;
          idx_n     = '0;
          roff_n    = '0;
          n_n       = n_sel;
          total_n   = frame_len(n_sel);
          tdata_n   = hdr_byte(5'd0, seq, n_sel);
          tvalid_n  = 1'b1;
          clr_flush = fifo_cnt <= MAX_C;
        end
      end
      default: begin
        if (tvalid_q && I_tx_axis_mac_tready) begin
          if (tlast_q) begin
            state_n  = IDLE;
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            tdata_n  = '0;
            done     = 1'b1;
          end else begin
            idx_n   = nidx;
            tlast_n = nidx == total - 11'd1;
            if (nidx < 11'd18) begin
              state_n = HDR;
              tdata_n = hdr_byte(nidx[4:0], seq, n_lat);
            end else if (nidx < rec_end) begin
              state_n = REC;
              // Pop as the record's first byte is loaded.
              if (roff == 3'd0) begin
                pop     = 1'b1;
                rec_n   = head;
                tdata_n = head[47:40];
                roff_n  = 3'd1;
              end else begin
                tdata_n = rec_byte(rec_q, roff);
                roff_n  = (roff == 3'd5) ? 3'd0 : roff + 3'd1;
              end
            end else begin
              state_n = PAD;
              tdata_n = '0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge I_tx_mac_aclk or posedge I_tx_reset) begin
    if (I_tx_reset) begin
      state     <= IDLE;
      idx       <= '0;
      roff      <= '0;
      n_lat     <= '0;
      total     <= '0;
      rec_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      seq       <= '0;
      frame_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      roff     <= roff_n;
      n_lat    <= n_n;
      total    <= total_n;
      rec_q    <= rec_n;
      tdata_q  <= tdata_n;
      tvalid_q <= tvalid_n;
      tlast_q  <= tlast_n;
      if (done) begin
        seq       <= seq + 16'd1;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign O_tx_axis_mac_tdata  = tdata_q;
  assign O_tx_axis_mac_tvalid = tvalid_q;
  assign O_tx_axis_mac_tlast  = tlast_q;
  assign O_fifo_overflow      = ovf;
  assign O_frame_cnt          = frame_cnt;

endmodule
